// File: rtl/mem_req_arbiter.sv
// Single-owner arbiter between ICache block fills and LSB accesses in front of the memory controller.
// Optional ICache starvation guard: define MEM_ARB_STARVE_GUARD_EN.
module mem_req_arbiter #(
  parameter int BLOCK_WIDTH  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic                           rdy_in,
  input  logic                           flush_signal,
  input  logic                           ic_req_en,
  input  logic [31:0]                    ic_req_addr,
  output logic                           ic_reply_en,
  output logic [(32<<BLOCK_WIDTH)-1:0]   ic_reply_data,
  input  logic                           lsb_req_en,
  input  logic                           lsb_req_type,
  input  logic [31:0]                    lsb_req_addr,
  input  logic [1:0]                     lsb_req_width,
  input  logic [31:0]                    lsb_req_data,
  output logic                           lsb_reply_en,
  output logic [31:0]                    lsb_reply_data,
  output logic                           mc_query_en,
  output logic                           mc_query_is_ic,
  output logic                           mc_query_type,
  output logic [31:0]                    mc_query_addr,
  output logic [1:0]                     mc_query_width,
  output logic [31:0]                    mc_query_data,
  input  logic                           mc_reply_en,
  input  logic [(32<<BLOCK_WIDTH)-1:0]   mc_reply_data
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_BUSY_IC  = 2'd1,
    ST_BUSY_LSB = 2'd2
  } state_e;

  state_e      state_r, state_s;
  logic        drop_r, drop_s;
  logic        q_en_r, q_en_s;
  logic        q_is_ic_r, q_is_ic_s;
  logic        q_type_r, q_type_s;
  logic [31:0] q_addr_r, q_addr_s;
  logic [1:0]  q_width_r, q_width_s;
  logic [31:0] q_data_r, q_data_s;

  logic idle_go_s;
  logic ic_force_s;
  logic lsb_grant_s;
  logic ic_grant_s;
  logic reply_ok_s;
  logic lsb_kill_s;

  assign idle_go_s   = rdy_in && (state_r == ST_IDLE);
  assign lsb_grant_s = idle_go_s && lsb_req_en && !flush_signal && !ic_force_s;
  assign ic_grant_s  = idle_go_s && ic_req_en && !lsb_grant_s;

  // A reply only counts while the controller is live and we are not being reset.
  assign reply_ok_s = rdy_in && !rst_in && mc_reply_en;
  assign lsb_kill_s = drop_r || (flush_signal && !q_type_r);

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

  logic [STARVE_W-1:0] starve_r, starve_s;

  assign ic_force_s = ic_req_en && (starve_r == STARVE_W'(STARVE_LIMIT));

  // Count LSB wins while the ICache is waiting; an ICache grant clears the count.
  always_comb begin
    starve_s = starve_r;
    if (ic_grant_s) begin
      starve_s = {STARVE_W{1'b0}};
    end else if (lsb_grant_s && ic_req_en && (starve_r != STARVE_W'(STARVE_LIMIT))) begin
      starve_s = starve_r + STARVE_W'(1);
    end else begin
      starve_s = starve_r;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      starve_r <= {STARVE_W{1'b0}};
    end else begin
      starve_r <= starve_s;
    end
  end
`else
  assign ic_force_s = 1'b0;
`endif

  // Next state and next query fields; rdy_in low freezes everything, including the issue pulse.
  always_comb begin
    state_s   = state_r;
    drop_s    = drop_r;
    q_en_s    = 1'b0;
    q_is_ic_s = q_is_ic_r;
    q_type_s  = q_type_r;
    q_addr_s  = q_addr_r;
    q_width_s = q_width_r;
    q_data_s  = q_data_r;
    if (!rdy_in) begin
      q_en_s = q_en_r;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (lsb_grant_s) begin
            state_s   = ST_BUSY_LSB;
            q_en_s    = 1'b1;
            q_is_ic_s = 1'b0;
            q_type_s  = lsb_req_type;
            q_addr_s  = lsb_req_addr;
            q_width_s = lsb_req_width;
            q_data_s  = lsb_req_data;
          end else if (ic_grant_s) begin
            state_s   = ST_BUSY_IC;
            q_en_s    = 1'b1;
            q_is_ic_s = 1'b1;
            q_type_s  = 1'b0;
            q_addr_s  = ic_req_addr;
            q_width_s = 2'd2;
            q_data_s  = 32'd0;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_BUSY_IC: begin
          if (mc_reply_en) begin
            state_s = ST_IDLE;
          end else begin
            state_s = ST_BUSY_IC;
          end
        end
        ST_BUSY_LSB: begin
          // Stores issue post-commit, so only a load can be killed by a flush.
          if (flush_signal && !q_type_r) begin
            drop_s = 1'b1;
          end else begin
            drop_s = drop_r;
          end
          if (mc_reply_en) begin
            state_s = ST_IDLE;
            drop_s  = 1'b0;
          end else begin
            state_s = ST_BUSY_LSB;
          end
        end
        default: begin
          state_s = ST_IDLE;
          drop_s  = 1'b0;
        end
      endcase
    end
  end

  // State, drop flag and registered query fields.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_r   <= ST_IDLE;
      drop_r    <= 1'b0;
      q_en_r    <= 1'b0;
      q_is_ic_r <= 1'b0;
      q_type_r  <= 1'b0;
      q_addr_r  <= 32'd0;
      q_width_r <= 2'd0;
      q_data_r  <= 32'd0;
    end else begin
      state_r   <= state_s;
      drop_r    <= drop_s;
      q_en_r    <= q_en_s;
      q_is_ic_r <= q_is_ic_s;
      q_type_r  <= q_type_s;
      q_addr_r  <= q_addr_s;
      q_width_r <= q_width_s;
      q_data_r  <= q_data_s;
    end
  end

  assign mc_query_en    = q_en_r;
  assign mc_query_is_ic = q_is_ic_r;
  assign mc_query_type  = q_type_r;
  assign mc_query_addr  = q_addr_r;
  assign mc_query_width = q_width_r;
  assign mc_query_data  = q_data_r;

  // Steer the controller reply to the owner in the same cycle it arrives.
  always_comb begin
    ic_reply_en    = 1'b0;
    ic_reply_data  = '0;
    lsb_reply_en   = 1'b0;
    lsb_reply_data = 32'd0;
    if (reply_ok_s && (state_r == ST_BUSY_IC)) begin
      ic_reply_en   = 1'b1;
      ic_reply_data = mc_reply_data;
    end else if (reply_ok_s && (state_r == ST_BUSY_LSB) && !lsb_kill_s) begin
      lsb_reply_en   = 1'b1;
      lsb_reply_data = mc_reply_data[31:0];
    end else begin
      ic_reply_en  = 1'b0;
      lsb_reply_en = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Randomized bench for mem_req_arbiter: requesters and controller are driven per protocol,
// and every cycle the outputs are compared against a transaction-level ownership model.
module tb_mem_req_arbiter;

  localparam int BW    = 2;
  localparam int DW    = 32 << BW;
  localparam int LIMIT = 4;
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic          clk_in;
  logic          rst_in;
  logic          rdy_in;
  logic          flush_signal;
  logic          ic_req_en;
  logic [31:0]   ic_req_addr;
  logic          ic_reply_en;
  logic [DW-1:0] ic_reply_data;
  logic          lsb_req_en;
  logic          lsb_req_type;
  logic [31:0]   lsb_req_addr;
  logic [1:0]    lsb_req_width;
  logic [31:0]   lsb_req_data;
  logic          lsb_reply_en;
  logic [31:0]   lsb_reply_data;
  logic          mc_query_en;
  logic          mc_query_is_ic;
  logic          mc_query_type;
  logic [31:0]   mc_query_addr;
  logic [1:0]    mc_query_width;
  logic [31:0]   mc_query_data;
  logic          mc_reply_en;
  logic [DW-1:0] mc_reply_data;

  mem_req_arbiter #(.BLOCK_WIDTH(BW), .STARVE_LIMIT(LIMIT)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .flush_signal   (flush_signal),
    .ic_req_en      (ic_req_en),
    .ic_req_addr    (ic_req_addr),
    .ic_reply_en    (ic_reply_en),
    .ic_reply_data  (ic_reply_data),
    .lsb_req_en     (lsb_req_en),
    .lsb_req_type   (lsb_req_type),
    .lsb_req_addr   (lsb_req_addr),
    .lsb_req_width  (lsb_req_width),
    .lsb_req_data   (lsb_req_data),
    .lsb_reply_en   (lsb_reply_en),
    .lsb_reply_data (lsb_reply_data),
    .mc_query_en    (mc_query_en),
    .mc_query_is_ic (mc_query_is_ic),
    .mc_query_type  (mc_query_type),
    .mc_query_addr  (mc_query_addr),
    .mc_query_width (mc_query_width),
    .mc_query_data  (mc_query_data),
    .mc_reply_en    (mc_reply_en),
    .mc_reply_data  (mc_reply_data)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_value(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: who owns the controller, how long it has owned it, and the issued transaction.
  int          owner;   // 0 none, 1 icache, 2 lsb
  int          age;
  int          lat;
  bit          killed;
  int          streak;
  logic        m_is_ic, m_type;
  logic [31:0] m_addr, m_data;
  logic [1:0]  m_width;
  bit          ic_pend, lsb_pend;
  bit          exp_ic, exp_lsb, force_ic;
  int          n_ic_grants, n_lsb_grants, n_kills;

  initial begin
    owner = 0; age = 0; lat = 1; killed = 0; streak = 0;
    m_is_ic = 1'b0; m_type = 1'b0; m_addr = 32'd0; m_data = 32'd0; m_width = 2'd0;
    ic_pend = 0; lsb_pend = 0;
    n_ic_grants = 0; n_lsb_grants = 0; n_kills = 0;
    rst_in = 1'b1; rdy_in = 1'b1; flush_signal = 1'b0;
    ic_req_en = 1'b0; ic_req_addr = 32'd0;
    lsb_req_en = 1'b0; lsb_req_type = 1'b0; lsb_req_addr = 32'd0;
    lsb_req_width = 2'd0; lsb_req_data = 32'd0;
    mc_reply_en = 1'b0; mc_reply_data = '0;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk_in);
      rst_in       = (cyc < 2) || ($urandom_range(0, 299) == 0);
      rdy_in       = ($urandom_range(0, 9) != 0);
      flush_signal = rdy_in && !rst_in && ($urandom_range(0, 11) == 0);
      if (!ic_pend && ($urandom_range(0, 2) == 0)) begin
        ic_pend     = 1;
        ic_req_addr = $urandom & 32'hFFFF_FFF0;
      end
      if (!lsb_pend && ($urandom_range(0, 1) == 0)) begin
        lsb_pend      = 1;
        lsb_req_type  = 1'($urandom_range(0, 1));
        lsb_req_addr  = $urandom;
        lsb_req_width = 2'($urandom_range(0, 2));
        lsb_req_data  = $urandom;
      end
      ic_req_en  = ic_pend;
      lsb_req_en = lsb_pend;
      if (owner != 0 && age >= lat) begin
        mc_reply_en = 1'b1;
      end else if (owner == 0 || !rdy_in) begin
        mc_reply_en = ($urandom_range(0, 9) == 0);
      end else begin
        mc_reply_en = 1'b0;
      end
      mc_reply_data = {$urandom, $urandom, $urandom, $urandom};

      #1;
      exp_ic  = !rst_in && rdy_in && mc_reply_en && owner == 1;
      exp_lsb = !rst_in && rdy_in && mc_reply_en && owner == 2 && !killed && !(flush_signal && !m_type);
      check_value("ic_reply_en", DW'(ic_reply_en), DW'(exp_ic));
      check_value("lsb_reply_en", DW'(lsb_reply_en), DW'(exp_lsb));
      if (exp_ic) check_value("ic_reply_data", ic_reply_data, mc_reply_data);
      if (exp_lsb) check_value("lsb_reply_data", DW'(lsb_reply_data), DW'(mc_reply_data[31:0]));
      check_value("mc_query_en", DW'(mc_query_en), DW'(owner != 0 && age == 0));
      check_value("mc_query_is_ic", DW'(mc_query_is_ic), DW'(m_is_ic));
      check_value("mc_query_type", DW'(mc_query_type), DW'(m_type));
      check_value("mc_query_addr", DW'(mc_query_addr), DW'(m_addr));
      check_value("mc_query_width", DW'(mc_query_width), DW'(m_width));
      if (!m_is_ic) check_value("mc_query_data", DW'(mc_query_data), DW'(m_data));

      @(posedge clk_in);
      if (rst_in) begin
        owner = 0; age = 0; killed = 0; streak = 0;
        m_is_ic = 1'b0; m_type = 1'b0; m_addr = 32'd0; m_data = 32'd0; m_width = 2'd0;
        ic_pend = 0; lsb_pend = 0;
      end else if (rdy_in) begin
        if (owner == 0) begin
          force_ic = GUARD && ic_req_en && streak >= LIMIT;
          if (lsb_req_en && !flush_signal && !force_ic) begin
            owner = 2; age = 0; lat = $urandom_range(1, 4);
            m_is_ic = 1'b0; m_type = lsb_req_type; m_addr = lsb_req_addr;
            m_width = lsb_req_width; m_data = lsb_req_data;
            if (ic_req_en && streak < LIMIT) streak++;
            n_lsb_grants++;
          end else if (ic_req_en) begin
            owner = 1; age = 0; lat = $urandom_range(1, 4);
            m_is_ic = 1'b1; m_type = 1'b0; m_addr = ic_req_addr;
            m_width = 2'd2; m_data = 32'd0;
            streak = 0;
            n_ic_grants++;
          end
        end else begin
          if (owner == 2 && flush_signal && !m_type) begin
            if (!killed) n_kills++;
            killed = 1;
          end
          if (mc_reply_en) begin
            owner = 0; killed = 0;
          end else begin
            age++;
          end
        end
        if (exp_ic) ic_pend = 0;
        if (exp_lsb) lsb_pend = 0;
        if (flush_signal && lsb_pend && !lsb_req_type) lsb_pend = 0;
      end
    end

    $display("grants: icache %0d, lsb %0d, killed loads %0d", n_ic_grants, n_lsb_grants, n_kills);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
